// File: rtl/intersection_phase_scheduler.sv
// Round-robin green-phase scheduler with min/max green, yellow, all-red clearance and emergency preemption.
// Lamps are registered and change one clk after the deciding condition; there is no backpressure, and the timer advances only on tick.
module intersection_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int ID_W      = 2,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [N_APPR-1:0] req,
  input  logic              preempt,
  input  logic [ID_W-1:0]   preempt_id,
  output logic [N_APPR-1:0] green,
  output logic [N_APPR-1:0] yellow,
  output logic [N_APPR-1:0] red,
  output logic [ID_W-1:0]   active_id,
  output logic              green_start
);

  typedef enum logic [1:0] {S_RED, S_GREEN, S_YELLOW} state_t;

  localparam logic [CNT_W-1:0] T_MIN    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_T);

  state_t            state;
  logic [CNT_W-1:0]  timer;
  logic [CNT_W-1:0]  timer_nxt;
  logic              sel_vld;
  logic [ID_W-1:0]   sel_id;
  logic [N_APPR-1:0] sel_mask;
  logic [N_APPR-1:0] act_mask;
  logic              others;
  logic              gap_out;
  logic              max_out;

  assign timer_nxt = (tick && (timer != {CNT_W{1'b1}})) ? timer + CNT_W'(1) : timer;
  assign sel_mask  = N_APPR'(1) << sel_id;
  assign act_mask  = N_APPR'(1) << active_id;
  assign others    = |(req & ~act_mask);
  assign gap_out   = (timer >= T_MIN) && !req[active_id] && others;
  assign max_out   = (timer >= T_MAX) && others;
  assign red       = ~(green | yellow);

  // Round-robin distance from active_id; active_id itself sits at distance N_APPR, i.e. last.
  always_comb begin
    int best;
    int d;
    sel_vld = 1'b0;
    sel_id  = active_id;
    best    = N_APPR + 1;
    d       = 0;
    if (preempt) begin
      sel_vld = 1'b1;
      sel_id  = preempt_id;
    end else begin
      for (int j = 0; j < N_APPR; j++) begin
        d = j - int'(active_id);
        if (d <= 0) d = d + N_APPR;
        if (req[j] && (d < best)) begin
          best    = d;
          sel_vld = 1'b1;
          sel_id  = ID_W'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RED;
      timer       <= T_ALLRED;
      active_id   <= '0;
      green       <= '0;
      yellow      <= '0;
      green_start <= 1'b0;
    end else begin
      green_start <= 1'b0;
      timer       <= timer_nxt;
      case (state)
        S_RED: begin
          if ((timer >= T_ALLRED) && sel_vld) begin
            state       <= S_GREEN;
            timer       <= '0;
            active_id   <= sel_id;
            green       <= sel_mask;
            green_start <= 1'b1;
          end
        end
        S_GREEN: begin
          // An active preempt overrides gap/max logic: either leave now or hold indefinitely.
          if (preempt ? (preempt_id != active_id) : (gap_out || max_out)) begin
            state  <= S_YELLOW;
            timer  <= '0;
            green  <= '0;
            yellow <= act_mask;
          end
        end
        S_YELLOW: begin
          if (timer >= T_YELLOW) begin
            state  <= S_RED;
            timer  <= '0;
            yellow <= '0;
          end
        end
        default: begin
          state  <= S_RED;
          timer  <= '0;
          green  <= '0;
          yellow <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with hand-computed phase timings.
// Lamps are sampled on the falling edge; inputs change on the falling edge.
module tb_intersection_phase_scheduler;

  localparam int MAX_GREEN = 40;
  localparam int YELLOW_T  = 4;
  localparam int ALLRED_T  = 2;
  localparam int LIMIT     = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_id;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic [1:0] active_id;
  logic       green_start;

  int checks = 0;
  int errors = 0;

  intersection_phase_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .req        (req),
    .preempt    (preempt),
    .preempt_id (preempt_id),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .active_id  (active_id),
    .green_start(green_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst        = 1'b1;
    req        = r;
    preempt    = 1'b0;
    preempt_id = 2'd0;
    tick       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // which: 0 green, 1 yellow, 2 red. n = falling edges stepped until the lamp equals pat, -1 on timeout.
  task automatic wait_lamp(input int which, input logic [3:0] pat, output int n);
    logic [3:0] cur;
    bit         hit;
    n   = -1;
    hit = 1'b0;
    for (int i = 1; i <= LIMIT && !hit; i++) begin
      @(negedge clk);
      cur = (which == 0) ? green : (which == 1) ? yellow : red;
      if (cur == pat) begin
        n   = i;
        hit = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    int bad;
    int pulses;
    rst = 1'b1; tick = 1'b1; req = 4'b0000; preempt = 1'b0; preempt_id = 2'd0;
    #1;
    check("rst_red", red, 4'b1111);
    check("rst_green", green, 4'b0000);
    check("rst_yellow", yellow, 4'b0000);
    check("rst_gstart", green_start, 0);
    check("rst_active", active_id, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests.
    pulses = 0; bad = 0;
    repeat (200) begin
      @(negedge clk);
      pulses += int'(green_start);
      if (red !== 4'b1111 || green !== 4'b0000) bad++;
    end
    check("idle_pulses", pulses, 0);
    check("idle_lamps_bad", bad, 0);
    check("idle_active", active_id, 0);

    // Lone request: clearance already met, so green on the first edge.
    req = 4'b0010;
    wait_lamp(0, 4'b0010, n);
    check("lone_green_lat", n, 1);
    check("lone_gstart", green_start, 1);
    check("lone_active", active_id, 1);
    pulses = 0; bad = 0;
    repeat (500) begin
      @(negedge clk);
      pulses += int'(green_start);
      if (green !== 4'b0010 || yellow !== 4'b0000) bad++;
    end
    check("lone_hold_pulses", pulses, 0);
    check("lone_hold_bad", bad, 0);

    // Max-out: the timer is compared before it increments, so each phase shows for limit+1 cycles.
    do_reset(4'b1010);
    wait_lamp(0, 4'b0010, n);
    check("mo_green1_lat", n, 1);
    wait_lamp(1, 4'b0010, n);
    check("mo_yellow1_lat", n, MAX_GREEN + 1);
    wait_lamp(2, 4'b1111, n);
    check("mo_red_lat", n, YELLOW_T + 1);
    wait_lamp(0, 4'b1000, n);
    check("mo_green3_lat", n, ALLRED_T + 1);
    check("mo_active3", active_id, 3);
    wait_lamp(1, 4'b1000, n);
    check("mo_yellow3_lat", n, MAX_GREEN + 1);
    wait_lamp(2, 4'b1111, n);
    check("mo_red2_lat", n, YELLOW_T + 1);
    wait_lamp(0, 4'b0010, n);
    check("mo_rr_back_to_1", n, ALLRED_T + 1);

    // Gap-out after min-green: drop at timer=12 gives yellow on the next edge.
    do_reset(4'b0110);
    wait_lamp(0, 4'b0010, n);
    check("go_green_lat", n, 1);
    repeat (12) @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    check("go_yellow_next", yellow, 4'b0010);
    check("go_green_off", green, 4'b0000);

    // Gap-out before min-green: drop at timer=3, yellow once timer reaches 10.
    do_reset(4'b0110);
    wait_lamp(0, 4'b0010, n);
    repeat (3) @(negedge clk);
    req = 4'b0100;
    wait_lamp(1, 4'b0010, n);
    check("mg_yellow_lat", n, 8);

    // Preempt to approach 0 while green on 2 with approach 3 waiting.
    do_reset(4'b0100);
    wait_lamp(0, 4'b0100, n);
    check("pe_green2_lat", n, 1);
    repeat (3) @(negedge clk);
    preempt = 1'b1; preempt_id = 2'd0; req = 4'b1000;
    @(negedge clk);
    check("pe_yellow_next", yellow, 4'b0100);
    wait_lamp(0, 4'b0001, n);
    check("pe_green0_lat", n, YELLOW_T + 1 + ALLRED_T + 1);
    check("pe_active0", active_id, 0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (green !== 4'b0001) bad++;
    end
    check("pe_hold_bad", bad, 0);

    // Preempt released with approach 3 waiting and timer past max: yellow next edge.
    preempt = 1'b0;
    @(negedge clk);
    check("tg_yellow0", yellow, 4'b0001);
    @(negedge clk);
    tick = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (yellow !== 4'b0001 || green !== 4'b0000) bad++;
    end
    check("tg_frozen_bad", bad, 0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("ar_red", red, 4'b1111);
    check("ar_yellow", yellow, 4'b0000);
    check("ar_green", green, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
